// File: rtl/mips_pkg.sv
// Shared constants for the mips_core CPU: opcodes, functs, CP0 register indices,
// exception codes and the fixed reset/handler/ack addresses.
package mips_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
  localparam logic [31:0] INT_ACK_ADDR = 32'h0000_7F20;
  localparam logic [31:0] TEXT_LO      = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI      = 32'h0000_6FFC;
  localparam logic [31:0] SR_WMASK     = 32'h0000_FC03;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
    OP_COP0  = 6'h10, OP_LB   = 6'h20, OP_LH  = 6'h21, OP_LW   = 6'h23,
    OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW  = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_JR  = 6'h08, F_ERET = 6'h18, F_ADDU = 6'h21,
    F_SUBU = 6'h23, F_AND = 6'h24, F_OR   = 6'h25, F_SLT  = 6'h2A
  } funct_e;

  typedef enum logic [4:0] {
    C0_MF = 5'h00, C0_MT = 5'h04, C0_CO = 5'h10
  } cop0_op_e;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10
  } exc_code_e;

endpackage

// File: rtl/mips_cp0.sv
// Coprocessor 0: SR/Cause/EPC, interrupt qualification and exception entry/return.
module mips_cp0
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_i,
  input  logic [31:0] pc_i,
  input  logic        exc_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        int_take_o,
  output logic [31:0] epc_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sr_q, sr_d, epc_q, epc_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] cause;

  assign int_take_o = irq_i & sr_q[12] & sr_q[0] & ~sr_q[1];
  assign cause      = {16'h0000, 3'b000, irq_i, 5'b00000, exc_code_q, 2'b00};
  assign epc_o      = epc_q;

  // Entry (interrupt or exception) outranks eret/mtc0; the core never issues them together.
  always_comb begin
    sr_d       = sr_q;
    epc_d      = epc_q;
    exc_code_d = exc_code_q;
    if (int_take_o || exc_i) begin
      epc_d      = pc_i;
      exc_code_d = int_take_o ? EXC_INT : exc_code_i;
      sr_d[1]    = 1'b1;
    end else if (eret_i) begin
      sr_d[1] = 1'b0;
    end else if (we_i) begin
      if (addr_i == CP0_SR) sr_d = wdata_i & SR_WMASK;
      else if (addr_i == CP0_EPC) epc_d = wdata_i;
    end
  end

  always_comb begin
    case (addr_i)
      CP0_SR:    rdata_o = sr_q;
      CP0_CAUSE: rdata_o = cause;
      CP0_EPC:   rdata_o = epc_q;
      default:   rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      epc_q      <= '0;
      exc_code_q <= '0;
    end else begin
      sr_q       <= sr_d;
      epc_q      <= epc_d;
      exc_code_q <= exc_code_d;
    end
  end

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS-subset core: decode, GRF, ALU, load/store lanes and next-PC;
// CP0 state and interrupt/exception entry live in mips_cp0.
module mips_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] grf_q [32];

  logic [31:0] instr, simm, zimm, rs_val, rt_val, addr, pc_plus4, br_target, j_target;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        known, wr, ld_mis, st_mis, is_eret, is_mtc0;
  logic [4:0]  wa;
  logic [31:0] wd, sdata, npc;
  logic [3:0]  be;

  logic        fetch_adel, exc, int_take, commit;
  logic [4:0]  exc_code;
  logic [31:0] cp0_rdata, epc;

  assign instr     = i_inst_rdata;
  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign simm      = {{16{instr[15]}}, instr[15:0]};
  assign zimm      = {16'h0000, instr[15:0]};
  assign rs_val    = grf_q[rs];
  assign rt_val    = grf_q[rt];
  assign addr      = rs_val + simm;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {simm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign ld_byte   = m_data_rdata[{addr[1:0], 3'b000} +: 8];
  assign ld_half   = m_data_rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    known   = 1'b0;
    wr      = 1'b0;
    wa      = rt;
    wd      = '0;
    be      = '0;
    sdata   = rt_val;
    npc     = pc_plus4;
    ld_mis  = 1'b0;
    st_mis  = 1'b0;
    is_eret = 1'b0;
    is_mtc0 = 1'b0;
    case (op)
      OP_RTYPE: begin
        known = 1'b1;
        wr    = 1'b1;
        wa    = rd;
        case (funct)
          F_ADDU:  wd = rs_val + rt_val;
          F_SUBU:  wd = rs_val - rt_val;
          F_AND:   wd = rs_val & rt_val;
          F_OR:    wd = rs_val | rt_val;
          F_SLT:   wd = {31'b0, $signed(rs_val) < $signed(rt_val)};
          F_SLL:   wd = rt_val << shamt;
          F_JR:    begin wr = 1'b0; npc = rs_val; end
          default: begin known = 1'b0; wr = 1'b0; end
        endcase
      end
      OP_J:     begin known = 1'b1; npc = j_target; end
      OP_JAL:   begin known = 1'b1; wr = 1'b1; wa = 5'd31; wd = pc_plus4; npc = j_target; end
      OP_BEQ:   begin known = 1'b1; if (rs_val == rt_val) npc = br_target; end
      OP_BNE:   begin known = 1'b1; if (rs_val != rt_val) npc = br_target; end
      OP_ADDIU: begin known = 1'b1; wr = 1'b1; wd = rs_val + simm; end
      OP_ORI:   begin known = 1'b1; wr = 1'b1; wd = rs_val | zimm; end
      OP_LUI:   begin known = 1'b1; wr = 1'b1; wd = {instr[15:0], 16'h0000}; end
      OP_LW:    begin known = 1'b1; wr = 1'b1; wd = m_data_rdata; ld_mis = (addr[1:0] != 2'b00); end
      OP_LH:    begin known = 1'b1; wr = 1'b1; wd = {{16{ld_half[15]}}, ld_half}; ld_mis = addr[0]; end
      OP_LB:    begin known = 1'b1; wr = 1'b1; wd = {{24{ld_byte[7]}}, ld_byte}; end
      OP_SW:    begin known = 1'b1; be = 4'b1111; st_mis = (addr[1:0] != 2'b00); end
      OP_SH: begin
        known  = 1'b1;
        be     = addr[1] ? 4'b1100 : 4'b0011;
        sdata  = {2{rt_val[15:0]}};
        st_mis = addr[0];
      end
      OP_SB:    begin known = 1'b1; be = 4'b0001 << addr[1:0]; sdata = {4{rt_val[7:0]}}; end
      OP_COP0: begin
        case (rs)
          C0_MF: begin known = 1'b1; wr = 1'b1; wd = cp0_rdata; end
          C0_MT: begin known = 1'b1; is_mtc0 = 1'b1; end
          C0_CO: if (funct == F_ERET) begin known = 1'b1; is_eret = 1'b1; npc = epc; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign fetch_adel = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  always_comb begin
    exc      = 1'b1;
    exc_code = EXC_ADEL;
    if (fetch_adel)   exc_code = EXC_ADEL;
    else if (!known)  exc_code = EXC_RI;
    else if (ld_mis)  exc_code = EXC_ADEL;
    else if (st_mis)  exc_code = EXC_ADES;
    else              exc = 1'b0;
  end

  mips_cp0 u_cp0 (
    .clk_i      (clk),
    .rst_ni     (reset),
    .irq_i      (interrupt),
    .pc_i       (pc_q),
    .exc_i      (reset & exc),
    .exc_code_i (exc_code),
    .eret_i     (commit & is_eret),
    .we_i       (commit & is_mtc0),
    .addr_i     (rd),
    .wdata_i    (rt_val),
    .int_take_o (int_take),
    .epc_o      (epc),
    .rdata_o    (cp0_rdata)
  );

  assign commit = reset & ~int_take & ~exc;
  assign pc_d   = (int_take || exc) ? HANDLER_PC : npc;

  assign macroscopic_pc = pc_q;
  assign i_inst_addr    = pc_q;
  assign m_inst_addr    = pc_q;
  assign w_inst_addr    = pc_q;
  assign m_data_addr    = addr;
  assign m_data_wdata   = sdata;
  assign m_data_byteen  = commit ? be : 4'b0000;
  assign m_int_byteen   = (reset & int_take) ? 4'b0001 : 4'b0000;
  assign m_int_addr     = (reset & int_take) ? INT_ACK_ADDR : 32'h0;
  assign w_grf_we       = commit & wr;
  assign w_grf_addr     = wa;
  assign w_grf_wdata    = wd;

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // $0 is never written, so reading it always yields zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (w_grf_we && (w_grf_addr != 5'd0)) begin
      grf_q[w_grf_addr] <= w_grf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: a fixed program with a shared trap handler, checked
// cycle by cycle against a hand-written retire trace.
module tb_mips_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
  logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;

  logic [31:0] rom [0:4095];
  logic [31:0] ram [0:1023];
  logic [31:0] romOff;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        irq;
  } step_t;
  step_t steps[$];

  mips_core dut (
    .clk            (clk),
    .reset          (reset),
    .interrupt      (interrupt),
    .macroscopic_pc (macroscopic_pc),
    .i_inst_addr    (i_inst_addr),
    .i_inst_rdata   (i_inst_rdata),
    .m_data_addr    (m_data_addr),
    .m_data_rdata   (m_data_rdata),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .m_inst_addr    (m_inst_addr),
    .w_grf_we       (w_grf_we),
    .w_grf_addr     (w_grf_addr),
    .w_grf_wdata    (w_grf_wdata),
    .w_inst_addr    (w_inst_addr)
  );

  always #5 clk = ~clk;

  assign romOff = i_inst_addr - 32'h0000_3000;
  always_comb begin
    if (i_inst_addr >= 32'h0000_3000 && i_inst_addr < 32'h0000_7000) i_inst_rdata = rom[romOff[13:2]];
    else i_inst_rdata = 32'h0;
  end
  assign m_data_rdata = ram[m_data_addr[11:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (m_data_byteen[b]) ram[m_data_addr[11:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic irq);
    interrupt = irq;
    #1;
  endtask

  task automatic addStep(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] sa, input logic [31:0] sd, input logic irq);
    step_t s;
    s.pc = pc; s.we = we; s.wa = wa; s.wd = wd; s.be = be; s.sa = sa; s.sd = sd; s.irq = irq;
    steps.push_back(s);
  endtask

  task automatic putWord(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] off;
    off = a - 32'h0000_3000;
    rom[off[13:2]] = w;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    putWord(32'h3000, 32'h3401_1234); // ori $1,$0,0x1234
    putWord(32'h3004, 32'h3C02_ABCD); // lui $2,0xabcd
    putWord(32'h3008, 32'h3442_ABCD); // ori $2,$2,0xabcd
    putWord(32'h300C, 32'hAC01_0000); // sw $1,0($0)
    putWord(32'h3010, 32'hA002_0005); // sb $2,5($0)
    putWord(32'h3014, 32'h8003_0005); // lb $3,5($0)
    putWord(32'h3018, 32'h8404_0004); // lh $4,4($0)
    putWord(32'h301C, 32'h0023_2821); // addu $5,$1,$3
    putWord(32'h3020, 32'h0001_3023); // subu $6,$0,$1
    putWord(32'h3024, 32'h00C1_382A); // slt $7,$6,$1
    putWord(32'h3028, 32'h1021_0001); // beq $1,$1,+1
    putWord(32'h302C, 32'h3408_DEAD); // ori $8 (skipped)
    putWord(32'h3030, 32'h1421_0001); // bne $1,$1,+1
    putWord(32'h3034, 32'h0C00_0C10); // jal 0x3040
    putWord(32'h3038, 32'h3409_0099); // ori $9,$0,0x99
    putWord(32'h303C, 32'h0800_0C14); // j 0x3050
    putWord(32'h3040, 32'h240A_FFFF); // addiu $10,$0,-1
    putWord(32'h3044, 32'h03E0_0008); // jr $31
    putWord(32'h3050, 32'h340B_1001); // ori $11,$0,0x1001
    putWord(32'h3054, 32'h408B_6000); // mtc0 $11,$12
    putWord(32'h3058, 32'h240C_0007); // addiu $12,$0,7
    putWord(32'h305C, 32'hFC00_0000); // undefined
    putWord(32'h3060, 32'h8C0D_0002); // lw $13,2($0)
    putWord(32'h3064, 32'hA401_0001); // sh $1,1($0)
    putWord(32'h3068, 32'h8C0E_0000); // lw $14,0($0)
    putWord(32'h306C, 32'h1000_FFFF); // beq $0,$0,-1
    // Handler: interrupts return to EPC, exceptions skip the faulting instruction.
    putWord(32'h4180, 32'h401A_6800); // mfc0 $26,Cause
    putWord(32'h4184, 32'h401B_7000); // mfc0 $27,EPC
    putWord(32'h4188, 32'h001A_D640); // sll $26,$26,25
    putWord(32'h418C, 32'h1340_0002); // beq $26,$0,+2
    putWord(32'h4190, 32'h277B_0004); // addiu $27,$27,4
    putWord(32'h4194, 32'h409B_7000); // mtc0 $27,EPC
    putWord(32'h4198, 32'h4200_0018); // eret

    addStep(32'h3000, 1, 1,  32'h0000_1234, 4'h0, 0, 0, 0);
    addStep(32'h3004, 1, 2,  32'hABCD_0000, 4'h0, 0, 0, 0);
    addStep(32'h3008, 1, 2,  32'hABCD_ABCD, 4'h0, 0, 0, 0);
    addStep(32'h300C, 0, 0,  0,             4'hF, 32'h0, 32'h0000_1234, 0);
    addStep(32'h3010, 0, 0,  0,             4'h2, 32'h5, 32'hCDCD_CDCD, 0);
    addStep(32'h3014, 1, 3,  32'hFFFF_FFCD, 4'h0, 0, 0, 0);
    addStep(32'h3018, 1, 4,  32'hFFFF_CD00, 4'h0, 0, 0, 0);
    addStep(32'h301C, 1, 5,  32'h0000_1201, 4'h0, 0, 0, 0);
    addStep(32'h3020, 1, 6,  32'hFFFF_EDCC, 4'h0, 0, 0, 0);
    addStep(32'h3024, 1, 7,  32'h0000_0001, 4'h0, 0, 0, 0);
    addStep(32'h3028, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3030, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3034, 1, 31, 32'h0000_3038, 4'h0, 0, 0, 0);
    addStep(32'h3040, 1, 10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    addStep(32'h3044, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3038, 1, 9,  32'h0000_0099, 4'h0, 0, 0, 0);
    addStep(32'h303C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3050, 1, 11, 32'h0000_1001, 4'h0, 0, 0, 0);
    addStep(32'h3054, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3058, 0, 0,  0,             4'h0, 0, 0, 1);
    addStep(32'h4180, 1, 26, 32'h0000_0000, 4'h0, 0, 0, 0);
    addStep(32'h4184, 1, 27, 32'h0000_3058, 4'h0, 0, 0, 0);
    addStep(32'h4188, 1, 26, 32'h0000_0000, 4'h0, 0, 0, 0);
    addStep(32'h418C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4198, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3058, 1, 12, 32'h0000_0007, 4'h0, 0, 0, 0);
    addStep(32'h305C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4180, 1, 26, 32'h0000_0028, 4'h0, 0, 0, 0);
    addStep(32'h4184, 1, 27, 32'h0000_305C, 4'h0, 0, 0, 0);
    addStep(32'h4188, 1, 26, 32'h5000_0000, 4'h0, 0, 0, 0);
    addStep(32'h418C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4190, 1, 27, 32'h0000_3060, 4'h0, 0, 0, 0);
    addStep(32'h4194, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4198, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3060, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4180, 1, 26, 32'h0000_0010, 4'h0, 0, 0, 0);
    addStep(32'h4184, 1, 27, 32'h0000_3060, 4'h0, 0, 0, 0);
    addStep(32'h4188, 1, 26, 32'h2000_0000, 4'h0, 0, 0, 0);
    addStep(32'h418C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4190, 1, 27, 32'h0000_3064, 4'h0, 0, 0, 0);
    addStep(32'h4194, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4198, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3064, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4180, 1, 26, 32'h0000_0014, 4'h0, 0, 0, 0);
    addStep(32'h4184, 1, 27, 32'h0000_3064, 4'h0, 0, 0, 0);
    addStep(32'h4188, 1, 26, 32'h2800_0000, 4'h0, 0, 0, 0);
    addStep(32'h418C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4190, 1, 27, 32'h0000_3068, 4'h0, 0, 0, 0);
    addStep(32'h4194, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h4198, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h3068, 1, 14, 32'h0000_1234, 4'h0, 0, 0, 0);
    addStep(32'h306C, 0, 0,  0,             4'h0, 0, 0, 0);
    addStep(32'h306C, 0, 0,  0,             4'h0, 0, 0, 0);

    reset = 1'b0;
    interrupt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.pc", macroscopic_pc, 32'h0000_3000);
    checkOutput("rst.we", {31'b0, w_grf_we}, 32'h0);
    checkOutput("rst.byteen", {28'b0, m_data_byteen}, 32'h0);
    checkOutput("rst.intbyteen", {28'b0, m_int_byteen}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i].irq);
      checkOutput($sformatf("c%0d.pc", i), macroscopic_pc, steps[i].pc);
      checkOutput($sformatf("c%0d.ipc", i), w_inst_addr, steps[i].pc);
      checkOutput($sformatf("c%0d.we", i), {31'b0, w_grf_we}, {31'b0, steps[i].we});
      if (steps[i].we) begin
        checkOutput($sformatf("c%0d.waddr", i), {27'b0, w_grf_addr}, {27'b0, steps[i].wa});
        checkOutput($sformatf("c%0d.wdata", i), w_grf_wdata, steps[i].wd);
      end
      checkOutput($sformatf("c%0d.byteen", i), {28'b0, m_data_byteen}, {28'b0, steps[i].be});
      if (steps[i].be != 4'h0) begin
        checkOutput($sformatf("c%0d.saddr", i), m_data_addr, steps[i].sa);
        checkOutput($sformatf("c%0d.sdata", i), m_data_wdata, steps[i].sd);
      end
      checkOutput($sformatf("c%0d.intbyteen", i), {28'b0, m_int_byteen}, steps[i].irq ? 32'h1 : 32'h0);
      checkOutput($sformatf("c%0d.intaddr", i), m_int_addr, steps[i].irq ? 32'h0000_7F20 : 32'h0);
      @(negedge clk);
    end

    checkOutput("ram.word0", ram[0], 32'h0000_1234);
    checkOutput("ram.word1", ram[1], 32'h0000_CD00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
